// File: rtl/analog_status_monitor.sv
// analog_status_monitor: synchronises NUM_CH analog status words into clk_in,
// records per-bit changes as sticky W1C flags, and exposes status, change
// flags and interrupt masks over a one-wait-state APB slave. irq_o is the
// registered OR of all unmasked change flags.

// tech_sync: behavioural stand-in for the technology synchroniser cell.
module tech_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff_r;

  // Shift the asynchronous input through DEPTH flops.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      ff_r <= '0;
    end else begin
      ff_r <= {ff_r[DEPTH-2:0], d};
    end
  end

  assign q = ff_r[DEPTH-1];

endmodule

module analog_status_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 32,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         reset_n,
  input  logic [11:0]                  PADDR,
  input  logic                         PENABLE,
  input  logic                         PSEL,
  input  logic [3:0]                   PSTRB,
  input  logic [31:0]                  PWDATA,
  input  logic                         PWRITE,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic [NUM_CH*CH_WIDTH-1:0]   status_i,
  output logic                         irq_o
);

  localparam int          NB         = NUM_CH * CH_WIDTH;
  localparam logic [2:0]  PRIME_DONE = 3'(SYNC_DEPTH + 1);
  localparam logic [31:0] INFO_VAL   = {8'h00, 8'(SYNC_DEPTH), 8'(CH_WIDTH), 8'(NUM_CH)};
  localparam logic [1:0]  OFF_STATUS  = 2'd0;
  localparam logic [1:0]  OFF_CHANGED = 2'd1;
  localparam logic [1:0]  OFF_MASK    = 2'd2;

  logic [NB-1:0]     sync_s;
  logic [NB-1:0]     stat_r;
  logic [NB-1:0]     chg_r;
  logic [NB-1:0]     mask_r;
  logic [NB-1:0]     chg_clr_s;
  logic [NB-1:0]     chg_set_s;
  logic [NB-1:0]     chg_nxt_s;
  logic [NB-1:0]     mask_nxt_s;
  logic [2:0]        prime_r;
  logic              detect_en_s;
  logic              accept_s;
  logic              wr_en_s;
  logic              err_s;
  logic              ch_hit_s;
  logic [NUM_CH-1:0] ch_sel_s;
  logic [31:0]       rdata_s;
  logic [31:0]       byte_mask_s;
  logic [31:0]       wr_val_s;
  logic [31:0]       stat_ch_s;
  logic [31:0]       chg_ch_s;
  logic [31:0]       mask_ch_s;
  logic [31:0]       pending_s;
  logic              pready_r;
  logic              pslverr_r;
  logic [31:0]       prdata_r;
  logic              irq_r;
  logic              unused_s;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_sync
      tech_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .d       (status_i[gi]),
        .q       (sync_s[gi])
      );
    end
  endgenerate

  assign accept_s    = PSEL & PENABLE & ~pready_r;
  assign detect_en_s = (prime_r == PRIME_DONE);
  assign byte_mask_s = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign wr_val_s    = PWDATA & byte_mask_s;
  assign ch_hit_s    = |ch_sel_s;
  assign wr_en_s     = accept_s & PWRITE & ~err_s;
  // A bit is flagged on the edge where stat_r loads a value different from its current one.
  assign chg_set_s   = detect_en_s ? (sync_s ^ stat_r) : '0;
  // Set has priority over a same-cycle W1C.
  assign chg_nxt_s   = chg_clr_s | chg_set_s;
  // Upper write-data bits have no storage when CH_WIDTH < 32.
  assign unused_s    = ^wr_val_s;

  // Decode the channel field and pick that channel's registers, zero-extended.
  always_comb begin
    ch_sel_s  = '0;
    stat_ch_s = 32'h0;
    chg_ch_s  = 32'h0;
    mask_ch_s = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (PADDR[10:4] == 7'(c)) begin
        ch_sel_s[c]              = 1'b1;
        stat_ch_s[CH_WIDTH-1:0]  = stat_r[c*CH_WIDTH +: CH_WIDTH];
        chg_ch_s[CH_WIDTH-1:0]   = chg_r[c*CH_WIDTH +: CH_WIDTH];
        mask_ch_s[CH_WIDTH-1:0]  = mask_r[c*CH_WIDTH +: CH_WIDTH];
      end else begin
        ch_sel_s[c] = 1'b0;
      end
    end
  end

  // Per-channel pending bits; unused upper bits stay 0.
  always_comb begin
    pending_s = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      pending_s[c] = |(chg_r[c*CH_WIDTH +: CH_WIDTH] & mask_r[c*CH_WIDTH +: CH_WIDTH]);
    end
  end

  // Address decode: read data and error classification for the current transfer.
  always_comb begin
    err_s   = 1'b0;
    rdata_s = 32'h0;
    if (PADDR[1:0] != 2'b00) begin
      err_s = 1'b1;
    end else if (PADDR[11]) begin
      case (PADDR[10:0])
        11'h000: begin rdata_s = pending_s; err_s = PWRITE; end
        11'h004: begin rdata_s = INFO_VAL;  err_s = PWRITE; end
        default: err_s = 1'b1;
      endcase
    end else if (!ch_hit_s) begin
      err_s = 1'b1;
    end else begin
      case (PADDR[3:2])
        OFF_STATUS:  begin rdata_s = stat_ch_s; err_s = PWRITE; end
        OFF_CHANGED: rdata_s = chg_ch_s;
        OFF_MASK:    rdata_s = mask_ch_s;
        default:     err_s = 1'b1;
      endcase
    end
  end

  // Register writes: W1C into the change flags, byte-enabled RW into the masks.
  always_comb begin
    chg_clr_s  = chg_r;
    mask_nxt_s = mask_r;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en_s && ch_sel_s[c]) begin
        case (PADDR[3:2])
          OFF_CHANGED: chg_clr_s[c*CH_WIDTH +: CH_WIDTH] =
                         chg_r[c*CH_WIDTH +: CH_WIDTH] & ~wr_val_s[CH_WIDTH-1:0];
          OFF_MASK:    mask_nxt_s[c*CH_WIDTH +: CH_WIDTH] =
                         (mask_r[c*CH_WIDTH +: CH_WIDTH] & ~byte_mask_s[CH_WIDTH-1:0]) |
                         wr_val_s[CH_WIDTH-1:0];
          default:     mask_nxt_s[c*CH_WIDTH +: CH_WIDTH] = mask_r[c*CH_WIDTH +: CH_WIDTH];
        endcase
      end else begin
        chg_clr_s[c*CH_WIDTH +: CH_WIDTH] = chg_r[c*CH_WIDTH +: CH_WIDTH];
      end
    end
  end

  // Status capture, sticky flags, masks and the post-reset prime counter.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stat_r  <= '0;
      chg_r   <= '0;
      mask_r  <= '0;
      prime_r <= 3'd0;
    end else begin
      stat_r <= sync_s;
      chg_r  <= chg_nxt_s;
      mask_r <= mask_nxt_s;
      if (prime_r != PRIME_DONE) begin
        prime_r <= prime_r + 3'd1;
      end else begin
        prime_r <= prime_r;
      end
    end
  end

  // APB response (one wait state) and registered interrupt.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= 32'h0;
      irq_r     <= 1'b0;
    end else begin
      pready_r  <= accept_s;
      pslverr_r <= accept_s & err_s;
      if (accept_s && !err_s && !PWRITE) begin
        prdata_r <= rdata_s;
      end else begin
        prdata_r <= prdata_r;
      end
      irq_r <= |pending_s;
    end
  end

  assign PRDATA  = prdata_r;
  assign PREADY  = pready_r;
  assign PSLVERR = pslverr_r;
  assign irq_o   = irq_r;

endmodule
